s32x_fb_blit: RTL and testbench
===============================

Name: s32x_fb_blit

Overview:
- Parametrised framebuffer block-transfer engine; successor to the 32X VDP auto-fill.
- Adds a copy mode, a configurable length and address wrap width, abort, and a grant handshake with the framebuffer port arbiter.
- Sits between the VDP register file (which supplies the START and parameters) and the draw-side framebuffer port.
- Writes one word per granted dot slot.

Parameters:
- AW, 16, framebuffer word-address width.
- DW, 16, data word width.
- LW, 8, length field width; the transfer moves LEN+1 words.
- WRAP_BITS, 8, low address bits that increment; upper AW-WRAP_BITS bits stay fixed for the whole transfer.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- CE  in  1  dot-slot enable; at most one framebuffer access per asserted CE.
- START  in  1  single-cycle pulse; latches MODE, LEN, SRC_A, DST_A, FILL_D.
- MODE  in  1  0 = fill, 1 = copy.
- LEN  in  LW  word count minus 1.
- SRC_A  in  AW  copy source start address.
- DST_A  in  AW  destination start address.
- FILL_D  in  DW  fill data.
- ABORT  in  1  terminates the transfer at the next cycle.
- BUSY  out  1  transfer in progress.
- DONE  out  1  one-cycle pulse on normal completion.
- CUR_A  out  AW  live destination address, for register readback.
- FB_GNT  in  1  arbiter grants the port this cycle.
- FB_A  out  AW  framebuffer address.
- FB_DO  out  DW  write data.
- FB_WE  out  2  byte write enables {upper, lower}.
- FB_RE  out  1  read strobe.
- FB_DI  in  DW  read data, valid the cycle after FB_RE.

Behaviour:
- **Reset** (RST high at a clock edge): state IDLE. BUSY=0, DONE=0, FB_WE=00, FB_RE=0, CUR_A=0, FB_A=0, FB_DO=0, counter=0. Reset mid-transfer abandons it with no further writes.
- **State machine:** IDLE, FILL, CP_RD, CP_WAIT, CP_WR.
- **IDLE:**
  - START latches all parameters: CNT<=LEN, DST<=DST_A, SRC<=SRC_A, DATA<=FILL_D.
  - Next state: FILL if MODE=0, CP_RD if MODE=1.
  - BUSY goes high in the cycle after START.
- **FILL:**
  - On a cycle with CE & FB_GNT: FB_A=DST, FB_DO=DATA, FB_WE=11 (combinational in that cycle).
  - DST low WRAP_BITS += 1 modulo 2^WRAP_BITS; upper bits unchanged.
  - If CNT==0, go to IDLE and pulse DONE; otherwise CNT -= 1.
  - Without CE & FB_GNT, nothing is driven and the state holds.
- **CP_RD:** on CE & FB_GNT, FB_A=SRC, FB_RE=1, then go to CP_WAIT.
- **CP_WAIT:** next cycle, register FB_DI into DATA, then go to CP_WR.
- **CP_WR:**
  - On CE & FB_GNT: write DATA to DST with FB_WE=11.
  - SRC and DST low WRAP_BITS each += 1 (same wrap rule).
  - Counter and exit rule as in FILL; otherwise return to CP_RD.
- **Word count:** exactly LEN+1 writes. LEN=0 gives 1 word; LEN=2^LW-1 gives 2^LW words.
- **Throughput:** fill is 1 word per granted slot; copy is 1 word per 2 granted slots minimum.
- **START while BUSY:** aborts the current transfer without DONE and restarts with the new parameters. Takes effect the next cycle; no write is issued in the START cycle.
- **ABORT:** returns to IDLE next cycle with no DONE pulse. ABORT has priority over a simultaneous START. In IDLE, ABORT has no effect.
- **Simultaneous last write and START:** the write completes, DONE is not pulsed, and the new transfer starts.
- **Outputs:**
  - CUR_A = DST register, so it reads the next address to be written; it holds its final value after completion.
  - DONE is high exactly one cycle, the cycle after the final write.
  - FB_WE and FB_RE are zero in every cycle where CE & FB_GNT is low.

Test Plan:
- Fill, LEN=3, DST_A=0x1234, FILL_D=0xA5A5, CE and FB_GNT always high -> writes to 0x1234..0x1237 all 0xA5A5; DONE 4 cycles after BUSY rises; CUR_A=0x1238.
- Wrap: fill with DST_A=0x12FE, LEN=3, WRAP_BITS=8 -> writes to 0x12FE, 0x12FF, 0x1200, 0x1201; the upper byte never changes.
- Copy, LEN=1, SRC_A=0x0010 holding 0x1111/0x2222, DST_A=0x0100 -> FB_RE at 0x10 then FB_WE at 0x100 with 0x1111, then the same for 0x11/0x2222; DONE once.
- Throttling: CE every 4th cycle and FB_GNT toggling -> writes occur only on CE & FB_GNT; write count still LEN+1; no writes in other cycles.
- Abort/restart:
  - ABORT after 2 of 8 fill words -> exactly 2 writes, no DONE, BUSY low next cycle.
  - START during a transfer -> new DST used from the next slot, no DONE for the first transfer.
- Reset/boundary:
  - RST mid-copy -> all outputs at reset values next cycle, no further FB_WE.
  - With LW=8, LEN=0xFF -> 256 writes.

Source files
------------

// File: rtl/s32x_fb_blit_if.sv
// ---------------------------------------------------------------------------
// s32x_fb_blit_if
// Draw-side framebuffer port between the block-transfer engine (master) and
// the framebuffer port arbiter / memory (slave).
//   FB_GNT  arbiter -> engine   port granted this cycle
//   FB_A    engine  -> fb       word address
//   FB_DO   engine  -> fb       write data
//   FB_WE   engine  -> fb       byte write enables {upper, lower}
//   FB_RE   engine  -> fb       read strobe
//   FB_DI   fb      -> engine   read data, valid the cycle after FB_RE
// ---------------------------------------------------------------------------
interface s32x_fb_blit_if #(
  parameter int AW = 16,
  parameter int DW = 16
) ();
  logic          FB_GNT;
  logic [AW-1:0] FB_A;
  logic [DW-1:0] FB_DO;
  logic [1:0]    FB_WE;
  logic          FB_RE;
  logic [DW-1:0] FB_DI;

  modport master (
    input  FB_GNT, FB_DI,
    output FB_A, FB_DO, FB_WE, FB_RE
  );

  modport slave (
    output FB_GNT, FB_DI,
    input  FB_A, FB_DO, FB_WE, FB_RE
  );
endinterface

// File: rtl/s32x_fb_blit.sv
// ---------------------------------------------------------------------------
// s32x_fb_blit
// Framebuffer block-transfer engine: fills a run of LEN+1 words with a
// constant, or copies LEN+1 words from SRC_A to DST_A. Only the low
// WRAP_BITS address bits advance; the upper bits stay fixed for a transfer.
// One framebuffer access is made per granted dot slot (CE & FB_GNT).
//
// Ports:
//   CLK, RST         clock, synchronous active-high reset
//   CE               dot-slot enable
//   START            one-cycle pulse, latches MODE/LEN/SRC_A/DST_A/FILL_D
//   MODE             0 = fill, 1 = copy
//   LEN              word count minus one
//   SRC_A, DST_A     copy source / destination start addresses
//   FILL_D           fill data
//   ABORT            stop the running transfer, no DONE
//   BUSY             transfer in progress
//   DONE             one-cycle pulse after the final write of a transfer
//   CUR_A            next destination address (register readback)
//   fb               framebuffer port (master side)
// ---------------------------------------------------------------------------
module s32x_fb_blit #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int LW        = 8,
  parameter int WRAP_BITS = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          CE,
  input  logic          START,
  input  logic          MODE,
  input  logic [LW-1:0] LEN,
  input  logic [AW-1:0] SRC_A,
  input  logic [AW-1:0] DST_A,
  input  logic [DW-1:0] FILL_D,
  input  logic          ABORT,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] CUR_A,
  s32x_fb_blit_if.master fb
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FILL    = 3'd1,
    ST_CP_RD   = 3'd2,
    ST_CP_WAIT = 3'd3,
    ST_CP_WR   = 3'd4
  } state_t;

  // Bits of the address that advance during a transfer.
  localparam logic [AW-1:0] LOW_MASK = {AW{1'b1}} >> (AW - WRAP_BITS);

  // Increment the low WRAP_BITS of an address, keeping the upper bits.
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    logic [AW-1:0] sum;
    sum = a + AW'(1);
    return (sum & LOW_MASK) | (a & ~LOW_MASK);
  endfunction

  state_t        state_r, state_s;
  logic [LW-1:0] cnt_r;
  logic [AW-1:0] dst_r;
  logic [AW-1:0] src_r;
  logic [DW-1:0] data_r;
  logic          busy_r;
  logic          done_r;

  logic          slot_s;
  logic          abort_s;
  logic          start_s;
  logic          last_s;
  logic          wr_s;
  logic          rd_s;
  logic          done_s;

  assign BUSY  = busy_r;
  assign DONE  = done_r;
  assign CUR_A = dst_r;

  // State register and transfer datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= {LW{1'b0}};
      dst_r   <= {AW{1'b0}};
      src_r   <= {AW{1'b0}};
      data_r  <= {DW{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != ST_IDLE);
      done_r  <= done_s;
      if (start_s) begin
        // A restart replaces the parameters even if the old transfer
        // made its last write in this same cycle.
        cnt_r  <= LEN;
        dst_r  <= DST_A;
        src_r  <= SRC_A;
        data_r <= FILL_D;
      end else begin
        if (wr_s) begin
          dst_r <= wrap_inc(dst_r);
          if (state_r == ST_CP_WR) begin
            src_r <= wrap_inc(src_r);
          end else begin
            src_r <= src_r;
          end
          if (!last_s) begin
            cnt_r <= cnt_r - LW'(1);
          end else begin
            cnt_r <= cnt_r;
          end
        end
        if (state_r == ST_CP_WAIT) begin
          data_r <= fb.FB_DI;
        end
      end
    end
  end

  // Next-state logic; ABORT beats START, and neither matters while idle
  // except START itself.
  always_comb begin
    state_s = state_r;
    if (abort_s) begin
      state_s = ST_IDLE;
    end else if (start_s) begin
      state_s = MODE ? ST_CP_RD : ST_FILL;
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_s = ST_IDLE;
        end
        ST_FILL: begin
          if (wr_s && last_s) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_FILL;
          end
        end
        ST_CP_RD: begin
          if (rd_s) begin
            state_s = ST_CP_WAIT;
          end else begin
            state_s = ST_CP_RD;
          end
        end
        ST_CP_WAIT: begin
          state_s = ST_CP_WR;
        end
        ST_CP_WR: begin
          if (wr_s) begin
            state_s = last_s ? ST_IDLE : ST_CP_RD;
          end else begin
            state_s = ST_CP_WR;
          end
        end
        default: begin
          state_s = ST_IDLE;
        end
      endcase
    end
  end

  // Framebuffer strobes; all accesses are gated by a granted slot, and an
  // aborting or resetting cycle issues nothing.
  always_comb begin
    slot_s   = CE & fb.FB_GNT & ~RST;
    abort_s  = ABORT & (state_r != ST_IDLE);
    start_s  = START & ~abort_s;
    last_s   = (cnt_r == {LW{1'b0}});
    wr_s     = 1'b0;
    rd_s     = 1'b0;
    fb.FB_A  = {AW{1'b0}};
    fb.FB_DO = {DW{1'b0}};
    fb.FB_WE = 2'b00;
    fb.FB_RE = 1'b0;
    case (state_r)
      ST_FILL, ST_CP_WR: begin
        if (slot_s && !abort_s) begin
          wr_s     = 1'b1;
          fb.FB_A  = dst_r;
          fb.FB_DO = data_r;
          fb.FB_WE = 2'b11;
        end else begin
          wr_s = 1'b0;
        end
      end
      ST_CP_RD: begin
        if (slot_s && !abort_s) begin
          rd_s     = 1'b1;
          fb.FB_A  = src_r;
          fb.FB_RE = 1'b1;
        end else begin
          rd_s = 1'b0;
        end
      end
      default: begin
        wr_s = 1'b0;
        rd_s = 1'b0;
      end
    endcase
    // A START on the final write restarts instead of completing.
    done_s = wr_s & last_s & ~start_s;
  end

endmodule

// File: tb/tb_s32x_fb_blit.sv
module tb_s32x_fb_blit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, gnt = 1'b0, start = 1'b0, mode = 1'b0, abort = 1'b0;
  logic [7:0]  len = 8'd0;
  logic [15:0] src_a = 16'd0, dst_a = 16'd0, fill_d = 16'd0, fb_di = 16'd0;
  logic        busy, done;
  logic [15:0] cur_a;

  int total = 0, bad = 0, cyc = 0, done_cnt = 0, done_cyc = 0, busy_rise = 0;
  logic busy_d = 1'b0;
  logic [31:0] wr_q[$];
  logic [31:0] exp_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] mem [0:65535];

  s32x_fb_blit_if #(.AW(16), .DW(16)) fb_if ();
  assign fb_if.FB_GNT = gnt;
  assign fb_if.FB_DI  = fb_di;

  s32x_fb_blit #(.AW(16), .DW(16), .LW(8), .WRAP_BITS(8)) dut (
    .CLK(clk), .RST(rst), .CE(ce), .START(start), .MODE(mode), .LEN(len),
    .SRC_A(src_a), .DST_A(dst_a), .FILL_D(fill_d), .ABORT(abort),
    .BUSY(busy), .DONE(done), .CUR_A(cur_a), .fb(fb_if)
  );

  always #5 clk = ~clk;

  // Framebuffer memory: read data appears the cycle after FB_RE.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fb_if.FB_RE) fb_di <= mem[fb_if.FB_A];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (fb_if.FB_WE !== 2'b00) begin
      wr_q.push_back({fb_if.FB_A, fb_if.FB_DO});
      chk("wr_strobe", {29'd0, fb_if.FB_WE, ce & gnt}, {29'd0, 2'b11, 1'b1});
    end
    if (fb_if.FB_RE) begin
      rd_q.push_back(fb_if.FB_A);
      chk("rd_strobe", {30'd0, ce & gnt, fb_if.FB_WE == 2'b00}, 32'd3);
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && !busy_d) busy_rise = cyc;
    busy_d = busy;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] wrap_add(input logic [15:0] a, input int i);
    return (a & 16'hFF00) | ((a + 16'(i)) & 16'h00FF);
  endfunction

  // Pulse START and queue the writes the transfer should produce.
  task automatic start_xfer(input logic m, input logic [7:0] l, input logic [15:0] s,
                            input logic [15:0] d, input logic [15:0] f);
    for (int i = 0; i <= int'(l); i++)
      exp_q.push_back({wrap_add(d, i), m ? mem[wrap_add(s, i)] : f});
    mode = m; len = l; src_a = s; dst_a = d; fill_d = f;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic drive_slot(input int cm, input int n);
    case (cm)
      0: begin ce = 1'b1; gnt = 1'b1; end
      1: begin ce = (n % 4 == 0); gnt = ((n / 4) % 2 == 0); end
      default: begin ce = 1'($urandom); gnt = 1'($urandom); end
    endcase
  endtask

  task automatic run_done(input int cm, input int budget, input int d0);
    int n;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      drive_slot(cm, n);
      tick();
      n++;
    end
    ce = 1'b0;
    gnt = 1'b0;
  endtask

  task automatic finish_xfer(input string tag, input int d0, input int exp_done,
                             input logic [15:0] exp_cur);
    repeat (3) tick();
    chk({tag, "_done"}, done_cnt - d0, exp_done);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_cur_a"}, cur_a, exp_cur);
    chk({tag, "_nwr"}, wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++)
      chk({tag, "_wr"}, wr_q[i], exp_q[i]);
    wr_q.delete();
    exp_q.delete();
    rd_q.delete();
  endtask

  initial begin
    int d0, nw;
    logic m;
    logic [7:0] l;
    logic [15:0] s, d, f;

    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);

    // Reset state
    tick(); tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cur_a", cur_a, 16'h0000);
    chk("rst_we", fb_if.FB_WE, 2'b00);
    chk("rst_re", fb_if.FB_RE, 1'b0);
    chk("rst_fb_a", fb_if.FB_A, 16'h0000);
    chk("rst_fb_do", fb_if.FB_DO, 16'h0000);
    rst = 1'b0;
    tick();

    // Basic fill, full rate
    d0 = done_cnt; ce = 1'b1; gnt = 1'b1;
    start_xfer(1'b0, 8'd3, 16'h0000, 16'h1234, 16'hA5A5);
    run_done(0, 50, d0);
    chk("fill_done_lat", done_cyc - busy_rise, 4);
    finish_xfer("fill", d0, 1, 16'h1238);

    // Address wrap within the low byte
    d0 = done_cnt; ce = 1'b1; gnt = 1'b1;
    start_xfer(1'b0, 8'd3, 16'h0000, 16'h12FE, 16'h5A3C);
    run_done(0, 50, d0);
    finish_xfer("wrap", d0, 1, 16'h1202);

    // Directed copy
    mem[16'h0010] = 16'h1111;
    mem[16'h0011] = 16'h2222;
    d0 = done_cnt;
    start_xfer(1'b1, 8'd1, 16'h0010, 16'h0100, 16'h0000);
    run_done(0, 50, d0);
    chk("copy_nrd", rd_q.size(), 2);
    if (rd_q.size() >= 2) begin
      chk("copy_rd0", rd_q[0], 16'h0010);
      chk("copy_rd1", rd_q[1], 16'h0011);
    end
    finish_xfer("copy", d0, 1, 16'h0102);

    // Throttled fill and copy
    d0 = done_cnt;
    start_xfer(1'b0, 8'd5, 16'h0000, 16'h4000, 16'h0F0F);
    run_done(1, 400, d0);
    finish_xfer("thr_fill", d0, 1, 16'h4006);
    d0 = done_cnt;
    start_xfer(1'b1, 8'd3, 16'h08FE, 16'h4480, 16'h0000);
    run_done(1, 600, d0);
    chk("thr_copy_nrd", rd_q.size(), 4);
    finish_xfer("thr_copy", d0, 1, 16'h4484);

    // ABORT after two fill words
    d0 = done_cnt; ce = 1'b1; gnt = 1'b1;
    start_xfer(1'b0, 8'd7, 16'h0000, 16'h2000, 16'h7777);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy_next", busy, 1'b0);
    repeat (4) tick();
    ce = 1'b0; gnt = 1'b0;
    finish_xfer("abort", d0, 0, 16'h2002);

    // START during a transfer, no slot in the START cycle
    d0 = done_cnt; ce = 1'b1; gnt = 1'b1;
    start_xfer(1'b0, 8'd7, 16'h0000, 16'h3000, 16'h1357);
    tick(); tick(); tick();
    while (exp_q.size() > 3) void'(exp_q.pop_back());
    ce = 1'b0;
    start_xfer(1'b0, 8'd1, 16'h0000, 16'h3400, 16'h2468);
    run_done(0, 50, d0);
    finish_xfer("restart", d0, 1, 16'h3402);

    // START coinciding with the last write of the previous transfer
    d0 = done_cnt; ce = 1'b1; gnt = 1'b1;
    start_xfer(1'b0, 8'd1, 16'h0000, 16'h5000, 16'hAAAA);
    tick();
    start_xfer(1'b0, 8'd0, 16'h0000, 16'h5800, 16'hBBBB);
    run_done(0, 50, d0);
    finish_xfer("last_start", d0, 1, 16'h5801);

    // Reset in the middle of a copy
    d0 = done_cnt; ce = 1'b1; gnt = 1'b1;
    start_xfer(1'b1, 8'd7, 16'h0200, 16'h0600, 16'h0000);
    repeat (5) tick();
    nw = wr_q.size();
    chk("rstmid_pre_wr", nw, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_busy", busy, 1'b0);
    chk("rstmid_done", done, 1'b0);
    chk("rstmid_cur_a", cur_a, 16'h0000);
    chk("rstmid_we", fb_if.FB_WE, 2'b00);
    chk("rstmid_re", fb_if.FB_RE, 1'b0);
    chk("rstmid_fb_a", fb_if.FB_A, 16'h0000);
    chk("rstmid_fb_do", fb_if.FB_DO, 16'h0000);
    repeat (8) tick();
    chk("rstmid_no_wr", wr_q.size(), nw);
    chk("rstmid_no_done", done_cnt - d0, 0);
    ce = 1'b0; gnt = 1'b0;
    wr_q.delete(); exp_q.delete(); rd_q.delete();

    // Maximum length: 256 words
    d0 = done_cnt; ce = 1'b1; gnt = 1'b1;
    start_xfer(1'b0, 8'hFF, 16'h0000, 16'h7F80, 16'hC3C3);
    run_done(0, 400, d0);
    finish_xfer("maxlen", d0, 1, 16'h7F80);

    // Randomised transfers under random slot availability
    for (int k = 0; k < 10; k++) begin
      m = 1'($urandom);
      l = 8'($urandom_range(0, 15));
      s = 16'($urandom);
      d = 16'($urandom);
      f = 16'($urandom);
      if (k % 3 == 0) d = (d & 16'hFF00) | 16'h00F8;
      d0 = done_cnt;
      start_xfer(m, l, s, d, f);
      run_done(2, 64 * (int'(l) + 1) + 64, d0);
      chk("rand_nrd", rd_q.size(), m ? int'(l) + 1 : 0);
      finish_xfer("rand", d0, 1, wrap_add(d, int'(l) + 1));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
